// File: rtl/serial_addsub.sv
// Bit-serial adder/subtractor with a result accumulator.
// A request is latched on a valid/ready handshake. The sum is then built one
// full-adder bit per cycle, LSB first. The finished result is held with
// out_valid until the consumer takes it.
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             sub,
  input  logic             acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             ovf,
  output logic             busy
);

  // WIDTH >= 2 keeps CW >= 1; the counter only needs to reach WIDTH-1.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             sum_bit;
  logic             cout;

  // Majority of three bits: the carry out of a full adder.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign sum_bit = a_q[0] ^ b_q[0] ^ c_q;
  assign cout    = maj(a_q[0], b_q[0], c_q);

  // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    acc_d   = acc_q;
    c_d     = c_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is A + ~B + 1: invert B and seed the carry with 1.
          a_d     = acc ? acc_q : op_a;
          b_d     = sub ? ~op_b : op_b;
          c_d     = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        res_d = {sum_bit, res_q[WIDTH-1:1]};
        c_d   = cout;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          // MSB step: c_q is the carry into the MSB, cout is the carry out of it.
          carry_d = cout;
          ovf_d   = c_q ^ cout;
          acc_d   = {sum_bit, res_q[WIDTH-1:1]};
          cnt_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      acc_q   <= '0;
      c_q     <= 1'b0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_addsub.sv
// Scoreboard bench for serial_addsub (WIDTH = 8): directed and random requests.
module tb_serial_addsub;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         sub;
  logic         acc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         ovf;
  logic         busy;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         o;
  } exp_t;

  exp_t         sb[$];
  int           n_checks = 0;
  int           n_err    = 0;
  int           model_acc = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .sub       (sub),
    .acc       (acc),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .carry     (carry),
    .ovf       (ovf),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: plain integer arithmetic on unsigned and signed views.
  function automatic exp_t model(input int a, input int b, input logic s);
    exp_t e;
    int full, sa, sb_, sr;
    full  = s ? (a - b) : (a + b);
    e.res = full[W-1:0];
    e.c   = s ? (a >= b) : (full >= (1 << W));
    sa    = (a >= (1 << (W-1))) ? a - (1 << W) : a;
    sb_   = (b >= (1 << (W-1))) ? b - (1 << W) : b;
    sr    = s ? (sa - sb_) : (sa + sb_);
    e.o   = (sr > (1 << (W-1)) - 1) || (sr < -(1 << (W-1)));
    return e;
  endfunction

  // Monitor: every consumed result must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", result, e.res);
        chk("carry", carry, e.c);
        chk("ovf", ovf, e.o);
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic ac, input int hold);
    int guard;
    int k;
    exp_t e;
    logic [W-1:0] held;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) chk("wait_in_ready", 0, 1);
    e = model(ac ? model_acc : int'(a), int'(b), s);
    sb.push_back(e);
    model_acc = int'(e.res);
    in_valid  = 1'b1;
    op_a      = a;
    op_b      = b;
    sub       = s;
    acc       = ac;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    // Scramble the operands after the accept; the operation must not notice.
    in_valid = 1'b0;
    op_a     = W'($urandom);
    op_b     = W'($urandom);
    sub      = 1'($urandom);
    acc      = 1'($urandom);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("latency", k, W);
    if (hold > 0) begin
      held = result;
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
        chk("hold_valid", out_valid, 1);
        chk("hold_in_ready", in_ready, 0);
        chk("hold_result", result, held);
        @(posedge clk); #1;
        in_valid = 1'b0;
      end
      out_ready = 1'b1;
    end
    @(posedge clk); #1;
    chk("idle_after", {busy, in_ready, out_valid}, 3'b010);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    op_a      = '0;
    op_b      = '0;
    sub       = 1'b0;
    acc       = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_result", result, 0);
    chk("rst_flags", {carry, ovf, out_valid, busy, in_ready}, 5'b00001);
    @(negedge clk);
    rst = 1'b0;

    // Accumulator chain straight after reset (first accept on first edge).
    do_op(8'h00, 8'h03, 1'b0, 1'b1, 0);
    do_op(8'h00, 8'h03, 1'b0, 1'b1, 0);
    do_op(8'h00, 8'h03, 1'b0, 1'b1, 0);
    do_op(8'h00, 8'h0A, 1'b1, 1'b1, 0);

    // Directed corner cases.
    do_op(8'h0F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h7F, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h05, 8'h07, 1'b1, 1'b0, 0);
    do_op(8'h80, 8'h01, 1'b1, 1'b0, 0);

    // Consumer stalls 5 cycles while requests are pulsed; then reuse acc.
    do_op(8'h21, 8'h13, 1'b0, 1'b0, 5);
    do_op(8'h00, 8'h00, 1'b0, 1'b1, 0);
    repeat (12) @(posedge clk);
    #1;
    chk("no_phantom_op", {busy, out_valid}, 2'b00);

    // Random requests with random consumer stalls.
    for (int i = 0; i < 40; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
            int'($urandom_range(0, 3)));
    end

    // Reset on the 3rd RUN cycle aborts the operation.
    @(negedge clk);
    in_valid = 1'b1;
    op_a     = 8'h55;
    op_b     = 8'h22;
    sub      = 1'b0;
    acc      = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("abort_flags", {busy, out_valid, in_ready}, 3'b001);
    chk("abort_result", result, 0);
    @(negedge clk);
    rst = 1'b0;
    model_acc = 0;
    do_op(8'h01, 8'h01, 1'b0, 1'b0, 0);
    do_op(8'h00, 8'h05, 1'b0, 1'b1, 0);

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
